// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready stream bundle for pipelined_barrel_shifter.
// The out_lost signal exists only when SHIFT_OUT_FLAG_EN is defined.
interface pipelined_barrel_shifter_if #(
    parameter int NBITS = 8
);
    localparam int NSTAGES = $clog2(NBITS);

    logic [NBITS-1:0]   in_data;
    logic [NSTAGES-1:0] in_amount;
    logic [1:0]         in_mode;
    logic               in_valid;
    logic               in_ready;
    logic [NBITS-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
`ifdef SHIFT_OUT_FLAG_EN
    logic               out_lost;
`endif

    modport master (
        output in_data, in_amount, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_valid
`ifdef SHIFT_OUT_FLAG_EN
        , input out_lost
`endif
    );

    modport slave (
        input  in_data, in_amount, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_valid
`ifdef SHIFT_OUT_FLAG_EN
        , output out_lost
`endif
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log2(NBITS)-stage barrel shifter (LSL/LSR/ASR/ROL) on a valid/ready stream.
// Optional SHIFT_OUT_FLAG_EN adds a sticky out_lost flag for bits shifted past the word boundary.
module pipelined_barrel_shifter #(
    parameter  int NBITS   = 8,
    localparam int NSTAGES = $clog2(NBITS)
) (
    input logic                        clk,
    input logic                        rst_n,
    pipelined_barrel_shifter_if.slave  bus
);
    typedef logic [NBITS-1:0]   word_t;
    typedef logic [NSTAGES-1:0] amt_t;
    typedef enum logic [1:0] {LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROL = 2'b11} mode_e;

    logic [NSTAGES-1:0] vld;
    logic [NSTAGES-1:0] load;
    logic               take;
    word_t              data_q [NSTAGES];
    amt_t               amt_q  [NSTAGES];
    mode_e              mode_q [NSTAGES];
    logic               msb_q  [NSTAGES];
`ifdef SHIFT_OUT_FLAG_EN
    logic               lost_q [NSTAGES];
`endif

    // Ready chain walks back to front: a stage loads when empty or when its successor drains it.
    always_comb begin
        load = '0;
        take = bus.out_ready;
        for (int unsigned i = 0; i < NSTAGES; i++) begin
            load[NSTAGES-1-i] = !vld[NSTAGES-1-i] || take;
            take              = load[NSTAGES-1-i];
        end
    end

    assign bus.in_ready  = rst_n && load[0];
    assign bus.out_valid = vld[NSTAGES-1];
    assign bus.out_data  = data_q[NSTAGES-1];
`ifdef SHIFT_OUT_FLAG_EN
    assign bus.out_lost  = lost_q[NSTAGES-1];
`endif

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int    SH = 1 << k;
        localparam word_t HI = ~({NBITS{1'b1}} >> SH);

        word_t sd, res, r_data;
        amt_t  sa, r_amt;
        mode_e sm, r_mode;
        logic  smsb, sv, r_msb, r_vld;
`ifdef SHIFT_OUT_FLAG_EN
        word_t drop;
        logic  slost, r_lost;
`endif

        if (k == 0) begin : g_head
            assign sd   = bus.in_data;
            assign sa   = bus.in_amount;
            assign sm   = mode_e'(bus.in_mode);
            assign smsb = bus.in_data[NBITS-1];
            assign sv   = bus.in_valid;
`ifdef SHIFT_OUT_FLAG_EN
            assign slost = 1'b0;
`endif
        end else begin : g_body
            assign sd   = data_q[k-1];
            assign sa   = amt_q[k-1];
            assign sm   = mode_q[k-1];
            assign smsb = msb_q[k-1];
            assign sv   = vld[k-1];
`ifdef SHIFT_OUT_FLAG_EN
            assign slost = lost_q[k-1];
`endif
        end

        // ASR fills from the original operand MSB, carried alongside the partial result.
        always_comb begin
            res = sd;
`ifdef SHIFT_OUT_FLAG_EN
            drop = '0;
`endif
            if (sa[k]) begin
                case (sm)
                    LSL: res = sd << SH;
                    LSR: res = sd >> SH;
                    ASR: res = (sd >> SH) | (smsb ? HI : '0);
                    ROL: res = (sd << SH) | (sd >> (NBITS - SH));
                    default: res = sd;
                endcase
`ifdef SHIFT_OUT_FLAG_EN
                case (sm)
                    LSL:      drop = sd >> (NBITS - SH);
                    LSR, ASR: drop = sd << (NBITS - SH);
                    default:  drop = '0;
                endcase
`endif
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_amt  <= '0;
                r_mode <= LSL;
                r_msb  <= 1'b0;
`ifdef SHIFT_OUT_FLAG_EN
                r_lost <= 1'b0;
`endif
            end else if (load[k]) begin
                r_vld <= sv;
                if (sv) begin
                    r_data <= res;
                    r_amt  <= sa;
                    r_mode <= sm;
                    r_msb  <= smsb;
`ifdef SHIFT_OUT_FLAG_EN
                    r_lost <= slost | (|drop);
`endif
                end
            end
        end

        assign vld[k]    = r_vld;
        assign data_q[k] = r_data;
        assign amt_q[k]  = r_amt;
        assign mode_q[k] = r_mode;
        assign msb_q[k]  = r_msb;
`ifdef SHIFT_OUT_FLAG_EN
        assign lost_q[k] = r_lost;
`endif
    end
endmodule
